// File: rtl/match_sequencer_if.sv
// rtl/match_sequencer_if.sv - serve/rally/score bundle between the sequencer and its rally datapath

interface match_sequencer_if;
  logic       new_game;
  logic       serve_ack;
  logic       point_a;
  logic       point_b;
  logic       serve_req;
  logic       server;
  logic       rally_active;
  logic [4:0] score_a;
  logic [4:0] score_b;
  logic       game_over;
  logic       winner;

  modport master (
    output new_game, serve_ack, point_a, point_b,
    input  serve_req, server, rally_active, score_a, score_b, game_over, winner
  );

  modport slave (
    input  new_game, serve_ack, point_a, point_b,
    output serve_req, server, rally_active, score_a, score_b, game_over, winner
  );
endinterface

// File: rtl/match_sequencer.sv
// rtl/match_sequencer.sv - game sequencer for serves, rallies, scoring and serve rotation (optional MATCH_SEQUENCER_DEUCE_EN)

module match_sequencer #(
  parameter int WIN_SCORE    = 11,
  parameter int SERVE_ROTATE = 2
) (
  input  logic              clk_in,
  input  logic              rst,
  match_sequencer_if.slave  bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SERVE = 3'd1;
  localparam logic [2:0] S_RALLY = 3'd2;
  localparam logic [2:0] S_SCORE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int         CW       = (SERVE_ROTATE > 1) ? $clog2(SERVE_ROTATE + 1) : 1;
  localparam logic [CW-1:0] ROT_LAST = CW'(SERVE_ROTATE - 1);
  localparam logic [4:0] WIN      = 5'(WIN_SCORE);
  localparam logic [4:0] SAT      = 5'd31;

  logic [2:0]    state_q, state_d;
  logic [4:0]    score_a_q, score_a_d;
  logic [4:0]    score_b_q, score_b_d;
  logic          server_q, server_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          winner_q, winner_d;

  logic deuce;
  logic a_wins;
  logic b_wins;

`ifdef MATCH_SEQUENCER_DEUCE_EN
  localparam logic [4:0] WIN_M1 = 5'(WIN_SCORE - 1);
  // Deuce: both players one point from winning; a win then needs a two-point lead.
  assign deuce  = (score_a_q >= WIN_M1) && (score_b_q >= WIN_M1);
  assign a_wins = ((score_a_q >= WIN) && ({1'b0, score_a_q} >= ({1'b0, score_b_q} + 6'd2)))
                  || (score_a_q == SAT);
  assign b_wins = ((score_b_q >= WIN) && ({1'b0, score_b_q} >= ({1'b0, score_a_q} + 6'd2)))
                  || (score_b_q == SAT);
`else
  assign deuce  = 1'b0;
  assign a_wins = (score_a_q >= WIN) || (score_a_q == SAT);
  assign b_wins = (score_b_q >= WIN) || (score_b_q == SAT);
`endif

  // Next-state and score/serve bookkeeping; new_game overrides everything else.
  always_comb begin
    state_d   = state_q;
    score_a_d = score_a_q;
    score_b_d = score_b_q;
    server_d  = server_q;
    cnt_d     = cnt_q;
    winner_d  = winner_q;
    if (bus.new_game) begin
      state_d   = S_SERVE;
      score_a_d = '0;
      score_b_d = '0;
      server_d  = 1'b0;
      cnt_d     = '0;
      winner_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: ;
        S_SERVE: if (bus.serve_ack) state_d = S_RALLY;
        S_RALLY: begin
          if (bus.point_a && bus.point_b) begin
            state_d = S_SERVE;
          end else if (bus.point_a) begin
            state_d = S_SCORE;
            if (score_a_q != SAT) score_a_d = score_a_q + 5'd1;
          end else if (bus.point_b) begin
            state_d = S_SCORE;
            if (score_b_q != SAT) score_b_d = score_b_q + 5'd1;
          end
        end
        S_SCORE: begin
          if (a_wins || b_wins) begin
            state_d  = S_DONE;
            winner_d = (score_b_q > score_a_q);
          end else begin
            state_d = S_SERVE;
            if (deuce || (cnt_q == ROT_LAST)) begin
              server_d = ~server_q;
              cnt_d    = '0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State registers with asynchronous reset back to an idle, cleared game.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      score_a_q <= '0;
      score_b_q <= '0;
      server_q  <= 1'b0;
      cnt_q     <= '0;
      winner_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      score_a_q <= score_a_d;
      score_b_q <= score_b_d;
      server_q  <= server_d;
      cnt_q     <= cnt_d;
      winner_q  <= winner_d;
    end
  end

  assign bus.serve_req    = (state_q == S_SERVE);
  assign bus.rally_active = (state_q == S_RALLY);
  assign bus.game_over    = (state_q == S_DONE);
  assign bus.server       = server_q;
  assign bus.score_a      = score_a_q;
  assign bus.score_b      = score_b_q;
  assign bus.winner       = winner_q;

endmodule

// File: tb/tb_match_sequencer.sv
// tb/tb_match_sequencer.sv - self-checking bench for match_sequencer

module tb_match_sequencer;

  localparam int W   = 11;
  localparam int ROT = 2;

  logic clk_in;
  logic rst;
  match_sequencer_if bus();

  match_sequencer #(.WIN_SCORE(W), .SERVE_ROTATE(ROT)) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (bus)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int vectors;
  int miscompares;

  // Reference game: scores, points played before deuce (p) and in deuce (d).
  int  sa, sb, p, d;
  bit  over, wnr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  function automatic int exp_srv();
    return ((p / ROT) + d) & 1;
  endfunction

  function automatic bit exp_over();
    int hi, lo;
    hi = (sa > sb) ? sa : sb;
    lo = (sa > sb) ? sb : sa;
`ifdef MATCH_SEQUENCER_DEUCE_EN
    return ((hi >= W) && (hi - lo >= 2)) || (hi >= 31);
`else
    return (hi >= W) || (hi >= 31);
`endif
  endfunction

  task automatic model_reset();
    sa = 0; sb = 0; p = 0; d = 0; over = 0; wnr = 0;
  endtask

  task automatic model_point(input bit to_b);
    if (to_b) begin if (sb < 31) sb++; end
    else      begin if (sa < 31) sa++; end
`ifdef MATCH_SEQUENCER_DEUCE_EN
    if (sa >= W - 1 && sb >= W - 1) d++; else p++;
`else
    p++;
`endif
    over = exp_over();
    wnr  = (sb > sa);
  endtask

  task automatic start_game();
    bus.new_game = 1'b1;
    tick();
    bus.new_game = 1'b0;
    model_reset();
    check("ng_serve_req", bus.serve_req, 1);
    check("ng_score_a", bus.score_a, 0);
    check("ng_score_b", bus.score_b, 0);
    check("ng_server", bus.server, 0);
    check("ng_game_over", bus.game_over, 0);
  endtask

  // kind: 0 = point A, 1 = point B, 2 = let. delay: cycles in SERVE before ack.
  task automatic do_point(input int kind, input int delay);
    check("serve_req", bus.serve_req, 1);
    check("server", bus.server, exp_srv());
    for (int i = 0; i < delay; i++) begin
      bus.point_a = 1'($urandom_range(0, 1));
      bus.point_b = 1'($urandom_range(0, 1));
      tick();
      bus.point_a = 1'b0;
      bus.point_b = 1'b0;
      check("serve_hold", bus.serve_req, 1);
      check("serve_srv_stable", bus.server, exp_srv());
      check("serve_ign_a", bus.score_a, sa);
      check("serve_ign_b", bus.score_b, sb);
    end
    bus.serve_ack = 1'b1;
    tick();
    bus.serve_ack = 1'b0;
    check("rally_active", bus.rally_active, 1);
    check("req_drop", bus.serve_req, 0);
    bus.point_a = (kind != 1);
    bus.point_b = (kind != 0);
    tick();
    bus.point_a = 1'b0;
    bus.point_b = 1'b0;
    if (kind == 2) begin
      check("let_req", bus.serve_req, 1);
      check("let_score_a", bus.score_a, sa);
      check("let_score_b", bus.score_b, sb);
      check("let_server", bus.server, exp_srv());
    end else begin
      model_point(kind == 1);
      check("score_a", bus.score_a, sa);
      check("score_b", bus.score_b, sb);
      check("score_cycle_req", bus.serve_req, 0);
      tick();
      check("game_over", bus.game_over, over);
      if (over) begin
        check("winner", bus.winner, wnr);
        check("done_req", bus.serve_req, 0);
      end else begin
        check("next_req", bus.serve_req, 1);
      end
    end
  endtask

  task automatic play_to(input int ta, input int tb);
    while (sa < ta || sb < tb)
      do_point((sa < ta && (sa <= sb || sb >= tb)) ? 0 : 1, 0);
  endtask

  initial begin
    int guard;
    vectors = 0;
    miscompares = 0;
    model_reset();
    bus.new_game = 1'b0; bus.serve_ack = 1'b0; bus.point_a = 1'b0; bus.point_b = 1'b0;
    rst = 1'b0;
    #2 rst = 1'b1;
    #2;
    check("rst_serve_req", bus.serve_req, 0);
    check("rst_server", bus.server, 0);
    check("rst_rally", bus.rally_active, 0);
    check("rst_score_a", bus.score_a, 0);
    check("rst_score_b", bus.score_b, 0);
    check("rst_game_over", bus.game_over, 0);
    check("rst_winner", bus.winner, 0);
    tick();
    rst = 1'b0;

    // IDLE ignores acks and points
    bus.serve_ack = 1'b1; bus.point_a = 1'b1;
    tick();
    bus.serve_ack = 1'b0; bus.point_a = 1'b0;
    check("idle_req", bus.serve_req, 0);
    check("idle_score", bus.score_a, 0);

    // Straight game to A: server 0,0,1,1,...
    start_game();
    for (int i = 0; i < W; i++) do_point(0, 0);
    check("a11_score_a", bus.score_a, 11);
    check("a11_score_b", bus.score_b, 0);
    check("a11_over", bus.game_over, 1);
    check("a11_winner", bus.winner, 0);

    // DONE freezes everything except new_game
    bus.point_b = 1'b1; bus.serve_ack = 1'b1;
    tick(); tick();
    bus.point_b = 1'b0; bus.serve_ack = 1'b0;
    check("done_frozen_b", bus.score_b, 0);
    check("done_hold", bus.game_over, 1);

    // Close game from 10-10
    start_game();
    play_to(10, 10);
    check("tie_over", bus.game_over, 0);
`ifdef MATCH_SEQUENCER_DEUCE_EN
    do_point(0, 0);
    check("d_11_10_over", bus.game_over, 0);
    do_point(1, 0);
    do_point(0, 0);
    do_point(0, 0);
    check("d_final_a", bus.score_a, 13);
    check("d_final_b", bus.score_b, 11);
    check("d_winner", bus.winner, 0);
`else
    do_point(1, 0);
    check("nd_final_b", bus.score_b, 11);
    check("nd_over", bus.game_over, 1);
    check("nd_winner", bus.winner, 1);
`endif

    // Let, then a long serve wait with ignored points
    start_game();
    play_to(2, 1);
    do_point(2, 0);
    do_point(0, 20);

    // Asynchronous reset mid-rally at 5-3
    start_game();
    play_to(5, 3);
    bus.serve_ack = 1'b1;
    tick();
    bus.serve_ack = 1'b0;
    check("pre_rst_rally", bus.rally_active, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_score_a", bus.score_a, 0);
    check("arst_score_b", bus.score_b, 0);
    check("arst_rally", bus.rally_active, 0);
    check("arst_server", bus.server, 0);
    check("arst_req", bus.serve_req, 0);
    check("arst_over", bus.game_over, 0);
    tick();
    rst = 1'b0;
    model_reset();
    tick(); tick(); tick();
    check("post_rst_idle", bus.serve_req, 0);

    // new_game during RALLY beats a same-cycle point
    start_game();
    play_to(1, 2);
    bus.serve_ack = 1'b1;
    tick();
    bus.serve_ack = 1'b0;
    bus.new_game = 1'b1; bus.point_a = 1'b1;
    tick();
    bus.new_game = 1'b0; bus.point_a = 1'b0;
    model_reset();
    check("abort_score_a", bus.score_a, 0);
    check("abort_score_b", bus.score_b, 0);
    check("abort_server", bus.server, 0);
    check("abort_req", bus.serve_req, 1);
    do_point(1, 0);

    // Random games
    for (int g = 0; g < 12; g++) begin
      start_game();
      guard = 0;
      while (!over && guard < 200) begin
        do_point(($urandom_range(0, 7) == 0) ? 2 : int'($urandom_range(0, 1)),
                 int'($urandom_range(0, 3)));
        guard++;
      end
      check("game_ends", over, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/match_sequencer.md
MATCH_SEQUENCER -- requirements
Module: match_sequencer

Interface
REQ-001 Parameter WIN_SCORE, default 11: points needed to win a game.
REQ-002 Parameter SERVE_ROTATE, default 2: total points between server changes outside deuce.
REQ-003 clk_in  input  1  system clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 new_game  input  1  one-cycle pulse; starts a fresh game.
REQ-006 serve_ack  input  1  rally datapath has accepted the serve.
REQ-007 point_a  input  1  one-cycle pulse; player A won the rally.
REQ-008 point_b  input  1  one-cycle pulse; player B won the rally.
REQ-009 serve_req  output  1  request to the rally datapath to launch a serve.
REQ-010 server  output  1  0 = A serves, 1 = B serves; valid while serve_req is high.
REQ-011 rally_active  output  1  high while a rally is in progress.
REQ-012 score_a, score_b  output  5 each  current game scores, unsigned.
REQ-013 game_over  output  1  high once the game is decided.
REQ-014 winner  output  1  0 = A, 1 = B; valid only while game_over is high.

Function
REQ-015 The FSM SHALL have states IDLE, SERVE, RALLY, SCORE and DONE, all registered.
REQ-016 IDLE: outputs held; new_game -> SERVE with scores 0, server 0, point counter 0.
REQ-017 SERVE: serve_req = 1 and server stable until serve_ack; serve_ack -> RALLY on the next edge; serve_req falls in the same cycle.
REQ-018 RALLY: rally_active = 1; exactly one of point_a/point_b -> SCORE; score increments on that edge.
REQ-019 If point_a and point_b are asserted together in RALLY, the rally is a let: scores, server and point counter are unchanged, and the FSM returns to SERVE.
REQ-020 point_a, point_b and serve_ack SHALL be ignored in every state except RALLY (points) or SERVE (ack).
REQ-021 SCORE, one cycle: evaluate win; on a win -> DONE, else apply server rotation -> SERVE.
REQ-022 Server rotation: increment the point counter; at SERVE_ROTATE, toggle server and clear the counter.
REQ-023 Deuce: both scores >= WIN_SCORE-1 (DEUCE_EN only); the server SHALL toggle after every point.
REQ-024 Score saturation: a score SHALL NOT exceed 31; a score of 31 wins outright regardless of margin.
REQ-025 DONE: game_over = 1, winner = higher scorer; scores frozen; only new_game leaves (-> SERVE, scores cleared).
REQ-026 new_game in SERVE, RALLY or SCORE SHALL abort the rally and restart exactly as from IDLE; it has priority over a same-cycle point or serve_ack.
REQ-027 Latency: point pulse -> score visible 1 cycle; point -> next serve_req 2 cycles.

Reset
REQ-028 rst SHALL force IDLE, serve_req = 0, server = 0, rally_active = 0, score_a = score_b = 0, game_over = 0, winner = 0, point counter = 0, immediately and independently of clk_in.
REQ-029 Deassertion of rst mid-rally SHALL leave the block in IDLE; a new_game is required before the next serve.

Configuration
REQ-030 Macro MATCH_SEQUENCER_DEUCE_EN defined: win = score >= WIN_SCORE and lead >= 2 (or 31 reached); deuce serve rule REQ-023 applies.
REQ-031 Macro MATCH_SEQUENCER_DEUCE_EN undefined: first score to reach WIN_SCORE wins; rotation is always per REQ-022.

Verification
REQ-032 rst, new_game, serve_ack, 11 point_a pulses -> score_a = 11, score_b = 0, game_over = 1, winner = 0; server sequence 0,0,1,1,0,0,...
REQ-033 DEUCE_EN: play to 10-10, then point_a -> 11-10, no game_over; point_b -> 11-11; point_a, point_a -> 13-11, winner = 0; server toggles on every point from 10-10.
REQ-034 DEUCE_EN undefined: play to 10-10, then point_b -> 10-11, game_over = 1, winner = 1.
REQ-035 In RALLY, point_a and point_b together -> scores unchanged, server unchanged, serve_req reasserted 1 cycle later.
REQ-036 Hold serve_ack low for 20 cycles in SERVE -> serve_req stays 1, server stable; point_a pulses during SERVE have no effect on score.
REQ-037 Assert rst asynchronously mid-RALLY at score 5-3 -> all outputs 0 before the next clock edge; new_game then new_game during RALLY -> scores 0-0, server 0.
